// File: rtl/spi_sprite_pkg.sv
// Shared types and default widths for the SPI sprite-position receiver.
package spi_sprite_pkg;

    localparam int DEF_COORD_W = 16;
    localparam int DEF_WORD_W  = 2 * DEF_COORD_W;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x;
        logic [DEF_COORD_W-1:0] y;
    } sprite_pos_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sync_falling_edge.sv
// Multi-flop synchroniser for a small bus; bit 0 gets a falling-edge pulse,
// and the last synchronised stage of every bit is exposed aligned with that pulse.
module sync_falling_edge #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             fall
);

    logic [WIDTH-1:0] stage [STAGES];
    logic             last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
            last_q <= 1'b0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            last_q <= stage[STAGES-1][0];
        end
    end

    assign dout = stage[STAGES-1];
    assign fall = last_q & ~stage[STAGES-1][0];

endmodule

// File: rtl/spi_sprite_receiver.sv
// Receives NUM_SPRITES {x,y} words over SPI (sampled in the pixel clock domain)
// and commits a complete staged frame to the renderers at the start of vsync.
module spi_sprite_receiver
    import spi_sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sck,
    input  logic                           sdi,
    input  logic                           vsync,
    output logic [NUM_SPRITES*COORD_W-1:0] xpos,
    output logic [NUM_SPRITES*COORD_W-1:0] ypos,
    output logic                           updated,
    output logic                           pending,
    output logic                           overrun,
    output logic                           framing_err
);

    localparam int WORD_W = 2 * COORD_W;
    localparam int BC_W   = $clog2(WORD_W + 1);
    localparam int WC_W   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int TC_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]        spi_sync;
    logic              sck_fall;
    logic              sdi_s;
    logic              vsync_level;
    logic              vsync_fall;
    logic              unused_ok;

    rx_state_t         state;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] word;
    logic [BC_W-1:0]   bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [TC_W-1:0]   tmo_cnt;
    logic [WORD_W-1:0] staging    [NUM_SPRITES];
    logic [WORD_W-1:0] pend_frame [NUM_SPRITES];
    logic [WORD_W-1:0] active     [NUM_SPRITES];

    logic              word_done;
    logic              frame_done;
    logic              commit;

    // sck and sdi share one synchroniser so the sampled data bit lines up with the edge pulse
    sync_falling_edge #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_spi_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({sdi, sck}),
        .dout  (spi_sync),
        .fall  (sck_fall)
    );

    sync_falling_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_vsync_sync (
        .clk   (clk),
        .reset (reset),
        .din   (vsync),
        .dout  (vsync_level),
        .fall  (vsync_fall)
    );

    assign sdi_s      = spi_sync[1];
    assign unused_ok  = vsync_level ^ spi_sync[0];
    assign word       = {shreg, sdi_s};
    assign word_done  = (state == RECV) && sck_fall && (bit_cnt == BC_W'(WORD_W - 1));
    assign frame_done = word_done && (word_cnt == WC_W'(NUM_SPRITES - 1));
    assign commit     = vsync_fall && pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
            updated     <= 1'b0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                staging[i]    <= '0;
                pend_frame[i] <= '0;
                active[i]     <= '0;
            end
        end else begin
            updated <= commit;
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) active[i] <= pend_frame[i];
            end

            // A completing frame always lands in pend_frame; a same-cycle commit has already taken the old one
            if (frame_done) begin
                for (int i = 0; i < NUM_SPRITES; i++)
                    pend_frame[i] <= (i == NUM_SPRITES - 1) ? word : staging[i];
                pending <= 1'b1;
                if (pending && !commit) overrun <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (sck_fall) begin
                        shreg   <= word[WORD_W-2:0];
                        bit_cnt <= BC_W'(1);
                        state   <= RECV;
                    end
                end
                default: begin
                    if (sck_fall) begin
                        tmo_cnt <= '0;
                        shreg   <= word[WORD_W-2:0];
                        if (word_done) begin
                            bit_cnt           <= '0;
                            staging[word_cnt] <= word;
                            if (frame_done) begin
                                word_cnt <= '0;
                                state    <= IDLE;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
                        tmo_cnt     <= '0;
                        bit_cnt     <= '0;
                        word_cnt    <= '0;
                        framing_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
        assign xpos[g*COORD_W +: COORD_W] = active[g][WORD_W-1:COORD_W];
        assign ypos[g*COORD_W +: COORD_W] = active[g][COORD_W-1:0];
    end

endmodule

// File: tb/tb_spi_sprite_receiver.sv
// Self-checking bench: directed frame table, overrun/timeout/reset/collision
// sequences, and random frames against a frame-level reference model.
module tb_spi_sprite_receiver;

    localparam int NS = 2;
    localparam int CW = 16;
    localparam int SS = 2;
    localparam int TO = 1024;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           sck = 1'b0;
    logic           sdi = 1'b0;
    logic           vsync = 1'b1;
    logic [NS*CW-1:0] xpos, ypos;
    logic           updated, pending, overrun, framing_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // frame-level reference model
    logic [31:0] m_x, m_y, m_px, m_py;
    bit          m_pending, m_overrun, m_ferr;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] ex;
        logic [31:0] ey;
    } vec_t;
    vec_t tbl [4];

    spi_sprite_receiver #(
        .NUM_SPRITES (NS),
        .COORD_W     (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .vsync       (vsync),
        .xpos        (xpos),
        .ypos        (ypos),
        .updated     (updated),
        .pending     (pending),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_x = '0; m_y = '0; m_px = '0; m_py = '0;
        m_pending = 0; m_overrun = 0; m_ferr = 0;
    endtask

    task automatic model_frame(input logic [31:0] w0, input logic [31:0] w1);
        if (m_pending) m_overrun = 1;
        m_px = {w1[31:16], w0[31:16]};
        m_py = {w1[15:0], w0[15:0]};
        m_pending = 1;
    endtask

    task automatic model_commit();
        if (m_pending) begin
            m_x = m_px;
            m_y = m_py;
            m_pending = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 31; i >= 32 - n; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1);
        send_bits(w0, 32);
        send_bits(w1, 32);
        model_frame(w0, w1);
    endtask

    task automatic do_vsync(input string name);
        logic exp_upd;
        exp_upd = m_pending;
        vsync = 1'b0;
        tick(SS);
        check({name, " updated early"}, updated, 1'b0);
        check({name, " xpos early"}, xpos, m_x);
        tick(1);
        model_commit();
        check({name, " updated"}, updated, exp_upd);
        check({name, " xpos"}, xpos, m_x);
        check({name, " ypos"}, ypos, m_y);
        check({name, " pending"}, pending, m_pending);
        tick(1);
        check({name, " updated width"}, updated, 1'b0);
        vsync = 1'b1;
        tick(SS + 2);
    endtask

    task automatic check_flags(input string name);
        check({name, " pending"}, pending, m_pending);
        check({name, " overrun"}, overrun, m_overrun);
        check({name, " framing_err"}, framing_err, m_ferr);
    endtask

    initial begin
        logic [31:0] r0, r1;

        tbl[0] = '{w0: 32'h014000F0, w1: 32'h00100020, ex: 32'h00100140, ey: 32'h002000F0};
        tbl[1] = '{w0: 32'h00010002, w1: 32'h00030004, ex: 32'h00030001, ey: 32'h00040002};
        tbl[2] = '{w0: 32'hFFFF0000, w1: 32'h0000FFFF, ex: 32'h0000FFFF, ey: 32'hFFFF0000};
        tbl[3] = '{w0: 32'h80000001, w1: 32'h12345678, ex: 32'h12348000, ey: 32'h56780001};

        model_reset();
        tick(3);
        check("reset xpos", xpos, '0);
        check("reset ypos", ypos, '0);
        check("reset updated", updated, 1'b0);
        check_flags("reset");
        reset = 1'b0;
        tick(SS + 2);

        // vsync with nothing staged must leave everything alone
        do_vsync("empty vsync");
        check_flags("empty vsync");

        for (int t = 0; t < 4; t++) begin
            send_frame(tbl[t].w0, tbl[t].w1);
            check("table pending", pending, 1'b1);
            do_vsync("table commit");
            check("table xpos", xpos, tbl[t].ex);
            check("table ypos", ypos, tbl[t].ey);
            check_flags("table");
        end

        // overrun: B replaces A before commit
        send_frame(32'h00010002, 32'h00030004);
        send_frame(32'h00050006, 32'h00070008);
        check_flags("overrun staged");
        do_vsync("overrun commit");
        check("overrun xpos", xpos, 32'h00070005);
        check("overrun ypos", ypos, 32'h00080006);

        // timeout discards a partial frame
        send_bits(32'hDEADBEEF, 20);
        tick(TO + 80);
        m_ferr = 1;
        check_flags("timeout");
        send_frame(32'h014000F0, 32'h00100020);
        do_vsync("after timeout");
        check("after timeout xpos", xpos, 32'h00100140);
        check("after timeout ypos", ypos, 32'h002000F0);
        check_flags("after timeout");

        // reset mid-frame
        send_bits(32'hA5A5A5A5, 32);
        send_bits(32'h5A5A5A5A, 8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        tick(SS + 2);
        check("midreset xpos", xpos, '0);
        check_flags("midreset");
        send_frame(32'h11112222, 32'h33334444);
        do_vsync("post reset");
        check("post reset xpos", xpos, 32'h33331111);
        check("post reset ypos", ypos, 32'h44442222);
        check_flags("post reset");

        // last sck edge of B lands on the same cycle as the vsync edge
        send_frame(32'h0AAA0BBB, 32'h0CCC0DDD);
        send_bits(32'h01230456, 32);
        send_bits(32'h07890ABC, 31);
        sdi = 1'b0;
        sck = 1'b1;
        tick(4);
        sck = 1'b0;
        vsync = 1'b0;
        tick(SS + 1);
        model_commit();
        model_frame(32'h01230456, 32'h07890ABC);
        check("collide updated", updated, 1'b1);
        check("collide xpos", xpos, 32'h0CCC0AAA);
        check("collide ypos", ypos, 32'h0DDD0BBB);
        check_flags("collide");
        tick(1);
        vsync = 1'b1;
        tick(SS + 4);
        do_vsync("collide next");
        check("collide next xpos", xpos, 32'h07890123);
        check_flags("collide next");

        for (int it = 0; it < 8; it++) begin
            r0 = $urandom;
            r1 = $urandom;
            send_frame(r0, r1);
            check_flags("random staged");
            if ($urandom_range(0, 1) == 1) do_vsync("random commit");
        end
        do_vsync("random flush");
        check_flags("random end");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
